// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: Diff = A - B - Bin, LSB first, one full-subtractor cell per clock.
// Optional signed-overflow output Ovf is built only when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Diff,
  output logic         Bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         Ovf
`endif
);

  localparam int unsigned CntW = $clog2(N);
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [N-1:0]    res_q;
  logic            br_q;
  logic [CntW-1:0] cnt_q;

`ifdef SERIAL_SUB_OVF_EN
  logic            sa_q;
  logic            sb_q;
`endif

  logic            a_bit;
  logic            b_bit;
  logic            d_bit;
  logic            br_next;
  logic [N-1:0]    res_next;

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  always_comb begin
    a_bit            = a_q[0];
    b_bit            = b_q[0];
    d_bit            = a_bit ^ b_bit ^ br_q;
    br_next          = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    res_next         = res_q;
    res_next[cnt_q]  = d_bit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      br_q      <= 1'b0;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Diff      <= '0;
      Bout      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      Ovf       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            a_q      <= A;
            b_q      <= B;
            br_q     <= Bin;
            res_q    <= '0;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            state_q  <= StRun;
`ifdef SERIAL_SUB_OVF_EN
            sa_q     <= A[N-1];
            sb_q     <= B[N-1];
`endif
          end
        end

        StRun: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_next;
          res_q <= res_next;
          if (cnt_q == CntLast) begin
            // Result registers update only here, so they hold the old result during RUN.
            Diff      <= res_next;
            Bout      <= br_next;
            out_valid <= 1'b1;
            state_q   <= StDone;
`ifdef SERIAL_SUB_OVF_EN
            Ovf       <= (sa_q != sb_q) && (res_next[N-1] != sa_q);
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule
